// File: rtl/pulse_gen_multi.sv
`default_nettype none
// pulse_gen_multi: N_CH independent edge-triggered pulse generators with run-time
// width, holdoff, trigger mode and a sticky lost-trigger flag.   Rev 1.0
module pulse_gen_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_x,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_holdoff,
  input  logic [1:0]       i_mode,
  input  logic [N_CH-1:0]  i_miss_clr,
  output logic [N_CH-1:0]  o_x,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_miss
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_RETRIG = 2'd1;
  localparam logic [1:0]       MODE_GATED  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hold, hold_nxt;
    logic [1:0]       mode, mode_nxt;
    logic             prev_x;
    logic             miss, miss_nxt, miss_set;
    logic             trig, retrig, gated, pulse_done;

    assign trig   = i_x[g] & ~prev_x;
    assign retrig = (mode == MODE_RETRIG);
    assign gated  = (mode == MODE_GATED);

    always_ff @(posedge clk) begin
      if (i_reset) begin
        state  <= IDLE;
        cnt    <= '0;
        hold   <= '0;
        mode   <= '0;
        prev_x <= 1'b0;
        miss   <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        hold   <= hold_nxt;
        mode   <= mode_nxt;
        prev_x <= i_x[g];
        miss   <= miss_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hold_nxt   = hold;
      mode_nxt   = mode;
      miss_set   = 1'b0;
      pulse_done = 1'b0;
      case (state)
        IDLE: begin
          // A zero-width trigger is a configuration no-op, not a lost trigger.
          if (trig && (i_width != '0)) begin
            state_nxt = PULSE;
            cnt_nxt   = i_width;
            hold_nxt  = i_holdoff;
            mode_nxt  = i_mode;
          end
        end
        PULSE: begin
          cnt_nxt = cnt - CNT_ONE;
          if (trig && retrig) begin
            if (i_width != '0) begin
              cnt_nxt  = i_width;
              hold_nxt = i_holdoff;
            end else begin
              pulse_done = (cnt == CNT_ONE);
            end
          end else begin
            miss_set   = trig;
            pulse_done = (cnt == CNT_ONE) || (gated && !i_x[g]);
          end
          if (pulse_done) begin
            if (hold != '0) begin
              state_nxt = HOLD;
              cnt_nxt   = hold;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end
        end
        HOLD: begin
          cnt_nxt  = cnt - CNT_ONE;
          miss_set = trig;
          if (cnt == CNT_ONE) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      // Set has priority over a coincident clear.
      miss_nxt = miss_set | (miss & ~i_miss_clr[g]);
    end

    assign o_x[g]    = (state == PULSE);
    assign o_busy[g] = (state != IDLE);
    assign o_miss[g] = miss;
  end

endmodule
`default_nettype wire

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, runtime-programmable pulse generator and successor to the single-channel fixed-width pulse block. Each channel turns a rising edge on its input into an output pulse. Width, holdoff (dead time) and trigger mode are set at run time, and each channel keeps a sticky flag recording lost triggers. It sits between asynchronous-looking status/strobe sources (already synchronised to clk) and downstream register/control logic that needs clean, bounded pulses.

## Interface
- N_CH, 4, number of independent channels (≥1)
- CNT_W, 8, width of the width/holdoff counters; max pulse/holdoff = 2^CNT_W−1 cycles

- clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_x  in  N_CH  trigger inputs, synchronous to clk
- i_width  in  CNT_W  pulse width in cycles, shared by all channels
- i_holdoff  in  CNT_W  dead time after a pulse in cycles, shared
- i_mode  in  2  0 = ONESHOT, 1 = RETRIG, 2 = GATED, 3 = treated as ONESHOT
- i_miss_clr  in  N_CH  per-channel clear of o_miss
- o_x  out  N_CH  pulse outputs (registered)
- o_busy  out  N_CH  channel not IDLE (in PULSE or HOLD)
- o_miss  out  N_CH  sticky: a trigger edge was ignored

## Operation
- Per channel: prev_x register. An edge occurs when i_x=1 and prev_x=0. prev_x <= i_x every cycle and is cleared to 0 by reset.
- FSM per channel: IDLE, PULSE, HOLD. A down counter cnt (CNT_W bits) plus latched width W, holdoff H and mode M.
- IDLE:
  - Edge with i_width≠0: latch W=i_width, H=i_holdoff, M=i_mode, load cnt=W, go to PULSE.
  - Edge with i_width=0: ignored. Stay IDLE; o_miss is not set.
- PULSE:
  - o_x=1. cnt decrements each cycle.
  - When cnt==1: go to HOLD with cnt=H if H≠0, else go to IDLE.
  - RETRIG: an edge in PULSE reloads cnt=i_width, relatches W/H, and stays in PULSE; o_x does not drop. If i_width=0 at that moment, the edge is ignored and the pulse continues.
  - GATED: if i_x=0 while in PULSE, the pulse ends early. Exit to HOLD or IDLE by the same H rule.
  - ONESHOT/GATED: an edge in PULSE is ignored and sets o_miss.
- HOLD:
  - o_x=0. cnt decrements. When cnt==1, go to IDLE.
  - An edge in HOLD sets o_miss in every mode.
- A held-high input never retriggers, because a new 0→1 transition is required.
- o_miss[i]:
  - Set on an ignored edge; cleared by i_miss_clr[i].
  - If set and clear occur in the same cycle, set wins.
- Config inputs are sampled only at trigger/retrigger. Changes mid-pulse have no effect on the running pulse.
- Channels are fully independent. Simultaneous edges on several channels are each handled in the same cycle.
- Reset: all channels go to IDLE, cnt=0, prev_x=0, o_x=0, o_busy=0, o_miss=0.
  - Reset mid-pulse terminates the pulse at the next clock.
  - An input held high through reset deassertion produces an edge in the first cycle after reset.

## Timing
- Edge sampled at clock t causes o_x=1 from cycle t+1 through t+W inclusive: exactly W cycles, 1-cycle latency.
- GATED: if i_x=0 is sampled at clock t during PULSE, o_x=0 from cycle t+1.
- HOLD occupies exactly H cycles after the last o_x=1 cycle. The earliest accepted new edge is sampled in the first IDLE cycle.
- With H=0, an edge sampled in the cycle immediately after the last pulse cycle is accepted. This gives back-to-back pulses with one low cycle minimum.
- o_busy and o_miss are registered; o_miss sets the cycle after the ignored edge.
- No combinational path from inputs to outputs.

## Test plan
- ONESHOT, W=3, H=0: single 1-cycle edge on ch0 at clock 10 → o_x[0] high for cycles 11–13; o_busy[0] low at 14; other channels stay 0.
- ONESHOT, W=4, H=2: second edge during the pulse → no extension, o_miss=1. Edge during HOLD → o_miss stays 1. i_miss_clr → 0 next cycle; clear together with an ignored edge → stays 1.
- RETRIG, W=5: edges at clocks 10 and 13 → o_x high for cycles 11–18 continuously. Changing i_width to 2 at clock 12 (no edge) has no effect.
- GATED, W=8: i_x high for clocks 10–12, low at 13 → o_x high for cycles 11–13. With H=3, o_busy is high through cycle 16.
- i_width=0 edge → no pulse, o_miss=0. Input held high for 20 cycles with W=2 → exactly one 2-cycle pulse.
- Reset asserted mid-pulse with i_x held high, then released → outputs 0 during reset. A new W-cycle pulse starts 1 cycle after the first post-reset clock.
